// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and FSM state type for the byte-enable data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {CLEAR, RUN} state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data, error flag.
// Zero latency; no flow control of its own.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              write,
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [XLEN-1:0]   rword,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wword,
  output logic [XLEN-1:0]   rdata,
  output logic              err
);

  logic            is_byte;
  logic            is_half;
  logic            is_word;
  logic            uns;
  logic            legal;
  logic [XLEN-1:0] shifted;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    uns     = 1'b0;
    legal   = 1'b1;
    case (funct3)
      F3_B:  is_byte = 1'b1;
      F3_H:  is_half = 1'b1;
      F3_W:  is_word = 1'b1;
      F3_BU: begin is_byte = 1'b1; uns = 1'b1; legal = !write; end
      F3_HU: begin is_half = 1'b1; uns = 1'b1; legal = !write; end
      default: legal = 1'b0;
    endcase
  end

  assign err     = !legal || (is_half && lane[0]) || (is_word && (lane != 2'd0));
  assign shifted = rword >> {lane, 3'b000};

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = '0;
    wword = wdata;
    rdata = '0;
    if (is_byte)      wword = {4{wdata[7:0]}};
    else if (is_half) wword = {2{wdata[15:0]}};
    if (!err && write) begin
      if (is_byte)      be = 4'b0001 << lane;
      else if (is_half) be = 4'b0011 << lane;
      else              be = 4'b1111;
    end
    if (!err && !write) begin
      if (is_byte)      rdata = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      else if (is_half) rdata = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      else              rdata = rword;
    end
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed RV32 load/store memory; 1-cycle registered response, zero-sweep after reset.
// req_ready drops while in the clear sweep or while an unconsumed response is held.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]  mem [DEPTH_WORDS];
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic [NB-1:0]    be;
  logic [XLEN-1:0]  wword;
  logic [XLEN-1:0]  ld_data;
  logic             acc_err;
  logic             unused_addr_hi;

  assign idx  = req_addr[IDX_W+1:2];
  assign lane = req_addr[1:0];
  // Upper address bits alias onto the array by design.
  assign unused_addr_hi = ^req_addr[XLEN-1:IDX_W+2];

  assign req_ready = !reset && (state == RUN) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .write  (req_write),
    .funct3 (req_funct3),
    .lane   (lane),
    .rword  (mem[idx]),
    .wdata  (req_wdata),
    .be     (be),
    .wword  (wword),
    .rdata  (ld_data),
    .err    (acc_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = RUN;
    end
  end

  // Stores commit on their accept edge, so a following load needs no bypass.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_rdata <= ld_data;
      resp_err   <= acc_err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be against a byte-array reference model.
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int vecs = 0;
  int errs = 0;
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  data_memory_be #(.XLEN(32), .DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Reference: memory is 256 bytes; access size and alignment rules applied directly.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] r, output logic e);
    int size;
    int base;
    bit uns;
    logic [31:0] v;
    size = 0;
    uns  = 0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = w ? 0 : 1; uns = 1; end
      3'd5: begin size = w ? 0 : 2; uns = 1; end
      default: size = 0;
    endcase
    base = int'(a % 256);
    if (size == 0) e = 1'b1;
    else           e = (base % size) != 0;
    r = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < size; i++) begin
          v = d >> (8 * i);
          ref_mem[base + i] = v[7:0];
        end
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        r = v;
      end
    end
  endfunction

  // Called at a negedge; returns 1ns after the accept edge with req_valid low.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errs++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b0;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    vecs++;
    if (n !== 64) begin
      errs++;
      $display("FAIL reset_sweep_len: got %0d not-ready cycles, required 64", n);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic test_extend();
    logic [31:0] exp_r;
    logic        exp_e;
    logic [2:0]  f3s [5]  = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [5] = '{32'h10, 32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] want [5] = '{32'h0, 32'hFFFF_FF99, 32'h0000_0099, 32'hFFFF_8899, 32'h0000_AABB};
    for (int i = 0; i < 5; i++) begin
      issue(i == 0, f3s[i], adrs[i], 32'h8899_AABB);
      model(i == 0, f3s[i], adrs[i], 32'h8899_AABB, exp_r, exp_e);
      vecs++;
      if (resp_valid !== 1'b1 || resp_rdata !== want[i] || resp_rdata !== exp_r || resp_err !== 1'b0) begin
        errs++;
        $display("FAIL extend_%0d: valid=%b rdata=%h err=%b, required 1 %h 0",
                 i, resp_valid, resp_rdata, resp_err, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_merge();
    logic [31:0] exp_r;
    logic        exp_e;
    logic [2:0]  f3s [4]  = '{3'd2, 3'd0, 3'd1, 3'd2};
    logic [31:0] adrs [4] = '{32'h20, 32'h21, 32'h22, 32'h20};
    logic [31:0] dats [4] = '{32'h1122_3344, 32'h0000_00EE, 32'h0000_5566, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(i != 3, f3s[i], adrs[i], dats[i]);
      model(i != 3, f3s[i], adrs[i], dats[i], exp_r, exp_e);
      vecs++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_r || resp_err !== exp_e) begin
        errs++;
        $display("FAIL merge_%0d: rdata=%h err=%b, required %h %b", i, resp_rdata, resp_err, exp_r, exp_e);
      end
      @(negedge clk);
    end
    vecs++;
    if (exp_r !== 32'h5566_EE44 || resp_rdata !== 32'h5566_EE44) begin
      errs++;
      $display("FAIL merge_final: rdata=%h, required 5566ee44", resp_rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] exp_r;
    logic        exp_e;
    logic        ws   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s  [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic [31:0] adrs [4] = '{32'h22, 32'h01, 32'h20, 32'h20};
    for (int i = 0; i < 4; i++) begin
      issue(ws[i], f3s[i], adrs[i], 32'hDEAD_BEEF);
      model(ws[i], f3s[i], adrs[i], 32'hDEAD_BEEF, exp_r, exp_e);
      vecs++;
      if (resp_rdata !== exp_r || resp_err !== exp_e || resp_err !== (i != 3)) begin
        errs++;
        $display("FAIL error_%0d: rdata=%h err=%b, required %h %b", i, resp_rdata, resp_err, exp_r, exp_e);
      end
      @(negedge clk);
    end
    vecs++;
    if (resp_rdata !== 32'h5566_EE44) begin
      errs++;
      $display("FAIL error_unchanged: rdata=%h, required 5566ee44", resp_rdata);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e1, e2, e3;
    logic        x1, x2, x3;
    model(1'b0, 3'd2, 32'h20, 32'h0, e1, x1);
    model(1'b1, 3'd0, 32'h23, 32'h77, e2, x2);
    model(1'b0, 3'd2, 32'h20, 32'h0, e3, x3);
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h23; req_wdata = 32'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== e1 || resp_err !== x1) begin
        errs++;
        $display("FAIL bp_hold_%0d: ready=%b valid=%b rdata=%h, required 0 1 %h", k, req_ready, resp_valid, resp_rdata, e1);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (resp_valid !== 1'b1 || resp_rdata !== e2 || resp_err !== x2) begin
      errs++;
      $display("FAIL bp_drain_store: valid=%b rdata=%h err=%b, required 1 %h %b", resp_valid, resp_rdata, resp_err, e2, x2);
    end
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vecs++;
    if (resp_valid !== 1'b1 || resp_rdata !== e3 || resp_rdata !== 32'h7766_EE44) begin
      errs++;
      $display("FAIL bp_drain_load: valid=%b rdata=%h, required 1 7766ee44", resp_valid, resp_rdata);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_no_dup: valid=%b, required 0", resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] exp_r, a, d;
    logic        exp_e, w;
    logic [2:0]  f3;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'h3F) | (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0);
      d  = $urandom;
      issue(w, f3, a, d);
      model(w, f3, a, d, exp_r, exp_e);
      vecs++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_r || resp_err !== exp_e) begin
        errs++;
        $display("FAIL random_%0d w=%b f3=%0d a=%h: rdata=%h err=%b, required %h %b",
                 i, w, f3, a, resp_rdata, resp_err, exp_r, exp_e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_r;
    logic        exp_e;
    int          n;
    issue(1'b1, 3'd2, 32'h100, 32'hCAFE_F00D);
    model(1'b1, 3'd2, 32'h100, 32'hCAFE_F00D, exp_r, exp_e);
    @(negedge clk);
    issue(1'b0, 3'd2, 32'h0, 32'h0);
    model(1'b0, 3'd2, 32'h0, 32'h0, exp_r, exp_e);
    vecs++;
    if (resp_rdata !== 32'hCAFE_F00D || resp_rdata !== exp_r || resp_err !== 1'b0) begin
      errs++;
      $display("FAIL wrap_alias: rdata=%h err=%b, required cafef00d 0", resp_rdata, resp_err);
    end
    resp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_resp: valid=%b ready=%b, required 0 0", resp_valid, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    vecs++;
    if (n !== 64) begin
      errs++;
      $display("FAIL resweep_len: got %0d not-ready cycles, required 64", n);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 3'd2, 32'(i * 4) | 32'h100, 32'h0);
      vecs++;
      if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        errs++;
        $display("FAIL cleared_%0d: rdata=%h err=%b, required 00000000 0", i, resp_rdata, resp_err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_merge();
    test_errors();
    test_backpressure();
    test_random();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
